// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/grant/result bundle between two ALU clients and the arbiter.
// Latency: none (wires only). Clients drive req/func/opnd/clr; the arbiter drives gnt/done/result/acc/busy.
// Backpressure: a client holds req (and its operands) until its done pulse.
// Ports (signals):
//   req0/req1     client requests          func0/func1   3-bit ALU function codes
//   opnd0/opnd1   operand A                clr0/clr1     clear accumulator instead of ALU op
//   gnt0/gnt1     registered grants        done0/done1   one-cycle completion pulses
//   result        last completed result    acc           accumulator (operand B)
//   busy          arbiter in EXEC or DONE
// Modports: master = client side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [2:0]       func0;
  logic [2:0]       func1;
  logic [WIDTH-1:0] opnd0;
  logic [WIDTH-1:0] opnd1;
  logic             clr0;
  logic             clr1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] acc;
  logic             busy;

  modport master (
    output req0, req1, func0, func1, opnd0, opnd1, clr0, clr1,
    input  gnt0, gnt1, done0, done1, result, acc, busy
  );

  modport slave (
    input  req0, req1, func0, func1, opnd0, opnd1, clr0, clr1,
    output gnt0, gnt1, done0, done1, result, acc, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU + accumulator between two requesters, ACC <= f(opnd, ACC).
// Latency: req seen at edge k -> gnt after k, done/result/acc after k+1, gnt/done drop after k+2.
// Backpressure: one operation per 3 cycles; requests arriving while busy wait for the next IDLE edge.
// Ports:
//   clock   rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     alu_arbiter_if.slave (requests in; grants, done pulses, result, acc, busy out)
// Configuration macro: ALU_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always beats requester 1, no round-robin pointer
//   undefined -> round-robin using a 1-bit "last granted" pointer (reset value 1)
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic          clock,
  input  logic          resetn,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             win;        // 0 = requester 0 wins, 1 = requester 1 wins

  // Operation latched at acceptance; inputs are ignored afterwards.
  logic             sel_q;
  logic [2:0]       func_q;
  logic [WIDTH-1:0] opnd_q;
  logic             clr_q;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             done0_q;
  logic             done1_q;

  logic [WIDTH-1:0] zeros_a;
  logic [WIDTH-1:0] ones_b;
  logic [WIDTH-1:0] alu_out;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 1 only wins when requester 0 is idle.
  always_comb begin
    win = ~bus.req0;
  end
`else
  logic last_q;

  // On contention the requester that was not served last wins;
  // a lone request wins regardless of the pointer.
  always_comb begin
    win = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= win;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU on the latched operand (A) and the accumulator (B)
  // ---------------------------------------------------------------------------
  always_comb begin
    zeros_a = '0;
    ones_b  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      zeros_a = zeros_a + WIDTH'(!opnd_q[i]);
      ones_b  = ones_b  + WIDTH'(acc_q[i]);
    end
  end

  always_comb begin
    alu_out = '0;
    case (func_q)
      3'd0: alu_out = ~opnd_q ^ acc_q;
      3'd1: alu_out = opnd_q ^ ~acc_q;
      3'd2: alu_out = ~(opnd_q & acc_q);
      3'd3: alu_out = opnd_q & acc_q;
      3'd4: alu_out = opnd_q + acc_q + WIDTH'(1);   // carry out dropped
      3'd5: alu_out = ~(opnd_q ^ acc_q);
      3'd6: alu_out = zeros_a;
      3'd7: alu_out = ones_b + zeros_a;
      default: alu_out = '0;
    endcase
    if (clr_q) begin
      alu_out = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered handshake outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sel_q    <= 1'b0;
      func_q   <= '0;
      opnd_q   <= '0;
      clr_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel_q  <= win;
            func_q <= win ? bus.func1 : bus.func0;
            opnd_q <= win ? bus.opnd1 : bus.opnd0;
            clr_q  <= win ? bus.clr1  : bus.clr0;
            gnt0_q <= ~win;
            gnt1_q <= win;
          end
        end
        EXEC: begin
          acc_q    <= alu_out;
          result_q <= alu_out;
          done0_q  <= ~sel_q;
          done1_q  <= sel_q;
        end
        DONE: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
        end
        default: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.result = result_q;
  assign bus.acc    = acc_q;
  assign bus.busy   = (state != IDLE);

endmodule
